ln_stats_pipeline: RTL and testbench

LayerNorm statistics front-end for the BERT LayerNorm datapath. It accepts one 768-element row of signed 16-bit activations as 12 consecutive 64-lane beats. It accumulates the row sum and sum of squares, then computes the row mean, the variance, and a piecewise-linear (PWL) inverse square root. It combines the accumulate, variance and PWL stages and feeds the downstream normalize stage, which receives the results together with a 2-bit bank (row slot) id.

---
 rtl/ln_stats_pipeline.sv | 174 +++++++++++++++++
 tb/tb_ln_stats_pipeline.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ln_stats_pipeline.sv
// LayerNorm row statistics: accumulates a 768-element row over 12 beats, then
// an 8-deep pipeline derives the mean, the saturated variance and a PWL 1/sqrt.
module ln_stats_pipeline (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_valid,
  input  logic [1023:0]       i_data_flat,
  output logic signed [31:0]  o_mean,
  output logic [15:0]         o_variance,
  output logic [15:0]         o_inv_sqrt,
  output logic                o_valid,
  output logic [1:0]          o_bank_id
);

  typedef struct packed {
    logic signed [31:0] mean;
    logic [15:0]        variance;
    logic [3:0]         k;
    logic [1:0]         bank;
  } ctx_t;

  localparam ctx_t CTX_ZERO = '{mean: 32'sd0, variance: 16'd0, k: 4'd0, bank: 2'd0};

  logic signed [15:0] lane_s;
  logic signed [31:0] lane_sq32_s;
  logic signed [21:0] lane_sum_s;
  logic [37:0]        lane_sq_s;

  logic [3:0]         beat_r;
  logic [1:0]         row_r;
  logic signed [26:0] sum_r;
  logic [40:0]        sq_r;
  logic               acc_done_r;
  logic [1:0]         acc_bank_r;

  logic signed [31:0] s4_s;
  logic signed [31:0] mean_s;
  logic [26:0]        mag_s;
  logic [51:0]        n_s;
  logic [51:0]        quot_s;
  logic [15:0]        var_s;
  logic [15:0]        v0_s;
  logic [3:0]         k_s;
  logic [14:0]        f_s;
  logic [15:0]        y4_s;
  logic [15:0]        y5_s;
  logic [15:0]        y6_s;

  logic [7:1]         vld_r;
  ctx_t               ctx_r [1:7];
  logic [51:0]        n1_r;
  logic [14:0]        f3_r;
  logic [15:0]        y4_r;
  logic [15:0]        y5_r;
  logic [15:0]        y6_r;
  logic [15:0]        y7_r;

  // Per-beat lane sum and sum of squares across the 64 lanes.
  always_comb begin
    lane_s      = 16'sd0;
    lane_sq32_s = 32'sd0;
    lane_sum_s  = 22'sd0;
    lane_sq_s   = 38'd0;
    for (int i = 0; i < 64; i++) begin
      lane_s      = $signed(i_data_flat[16*i +: 16]);
      lane_sq32_s = 32'(lane_s) * 32'(lane_s);
      lane_sum_s  = lane_sum_s + {{6{lane_s[15]}}, lane_s};
      lane_sq_s   = lane_sq_s + {6'd0, lane_sq32_s};
    end
  end

  // Beat/row counters and row accumulators; beat 0 restarts the row.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      beat_r     <= 4'd0;
      row_r      <= 2'd0;
      sum_r      <= 27'sd0;
      sq_r       <= 41'd0;
      acc_done_r <= 1'b0;
      acc_bank_r <= 2'd0;
    end else if (i_en) begin
      acc_done_r <= 1'b0;
      if (i_valid) begin
        if (beat_r == 4'd0) begin
          sum_r <= {{5{lane_sum_s[21]}}, lane_sum_s};
          sq_r  <= {3'd0, lane_sq_s};
        end else begin
          sum_r <= sum_r + {{5{lane_sum_s[21]}}, lane_sum_s};
          sq_r  <= sq_r + {3'd0, lane_sq_s};
        end
        if (beat_r == 4'd11) begin
          beat_r     <= 4'd0;
          row_r      <= row_r + 2'd1;
          acc_done_r <= 1'b1;
          acc_bank_r <= row_r;
        end else begin
          beat_r <= beat_r + 4'd1;
        end
      end
    end
  end

  // Stage 1 math: floored mean (S*4/3) and N = 768*Q - S^2.
  always_comb begin
    s4_s = {{3{sum_r[26]}}, sum_r, 2'b00};
    if (s4_s[31]) begin
      mean_s = -((-s4_s + 32'sd2) / 32'sd3);
    end else begin
      mean_s = s4_s / 32'sd3;
    end
    mag_s = sum_r[26] ? -sum_r : sum_r;
    n_s   = ({11'd0, sq_r} * 52'd768) - ({25'd0, mag_s} * {25'd0, mag_s});
  end

  // Stages 2..6 math: saturated variance, exponent/fraction, PWL and odd-k fixup.
  always_comb begin
    quot_s = n1_r / 52'd589824;
    var_s  = (quot_s > 52'd65535) ? 16'hFFFF : quot_s[15:0];
    v0_s   = (ctx_r[2].variance == 16'd0) ? 16'd1 : ctx_r[2].variance;
    k_s    = 4'd0;
    for (int i = 1; i < 16; i++) begin
      k_s = v0_s[i] ? 4'(i) : k_s;
    end
    f_s  = 15'({v0_s, 15'd0} >> k_s);
    y4_s = 16'h8000 - 16'(({17'd0, f3_r} * 32'd9598) >> 15);
    y5_s = ctx_r[4].k[0] ? 16'(({16'd0, y4_r} * 32'd23170) >> 15) : y4_r;
    y6_s = y5_r >> ctx_r[5].k[3:1];
  end

  // Stats pipeline and output registers, all frozen while i_en is low.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_r      <= 7'd0;
      n1_r       <= 52'd0;
      f3_r       <= 15'd0;
      y4_r       <= 16'd0;
      y5_r       <= 16'd0;
      y6_r       <= 16'd0;
      y7_r       <= 16'd0;
      for (int i = 1; i <= 7; i++) ctx_r[i] <= CTX_ZERO;
      o_mean     <= 32'sd0;
      o_variance <= 16'd0;
      o_inv_sqrt <= 16'd0;
      o_valid    <= 1'b0;
      o_bank_id  <= 2'd0;
    end else if (i_en) begin
      vld_r             <= {vld_r[6:1], acc_done_r};
      ctx_r[1]          <= '{mean: mean_s, variance: 16'd0, k: 4'd0, bank: acc_bank_r};
      n1_r              <= n_s;
      ctx_r[2]          <= ctx_r[1];
      ctx_r[2].variance <= var_s;
      ctx_r[3]          <= ctx_r[2];
      ctx_r[3].k        <= k_s;
      f3_r              <= f_s;
      ctx_r[4]          <= ctx_r[3];
      y4_r              <= y4_s;
      ctx_r[5]          <= ctx_r[4];
      y5_r              <= y5_s;
      ctx_r[6]          <= ctx_r[5];
      y6_r              <= y6_s;
      ctx_r[7]          <= ctx_r[6];
      y7_r              <= y6_r;
      o_valid           <= vld_r[7];
      if (vld_r[7]) begin
        o_mean     <= ctx_r[7].mean;
        o_variance <= ctx_r[7].variance;
        o_inv_sqrt <= y7_r;
        o_bank_id  <= ctx_r[7].bank;
      end
    end
  end

endmodule

// File: tb/tb_ln_stats_pipeline.sv
// Scoreboard bench for ln_stats_pipeline: rows are modelled with plain integer
// arithmetic at issue time; a monitor pops and checks every o_valid pulse.
module tb_ln_stats_pipeline;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               valid;
  logic [1023:0]      data;
  logic signed [31:0] mean;
  logic [15:0]        variance;
  logic [15:0]        inv_sqrt;
  logic               out_valid;
  logic [1:0]         bank;

  always #5 clk = ~clk;

  ln_stats_pipeline dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_valid    (valid),
    .i_data_flat(data),
    .o_mean     (mean),
    .o_variance (variance),
    .o_inv_sqrt (inv_sqrt),
    .o_valid    (out_valid),
    .o_bank_id  (bank)
  );

  typedef struct {
    longint mean;
    longint variance;
    longint inv;
    longint bank;
    longint due;
  } exp_t;

  exp_t   sb_q[$];
  int     checks = 0;
  int     errors = 0;
  longint en_count = 0;
  int     row_count = 0;
  int     row [768];

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: row statistics straight from the arithmetic definitions.
  function automatic exp_t model(int b, longint due);
    exp_t   e;
    longint s = 0, q = 0, s4, n, v, k, f, y;
    for (int i = 0; i < 768; i++) begin
      s += row[i];
      q += longint'(row[i]) * row[i];
    end
    s4 = 4 * s;
    e.mean = s4 / 3;
    if (s4 < 0 && (s4 % 3) != 0) e.mean = e.mean - 1;
    n = 768 * q - s * s;
    e.variance = n / 589824;
    if (e.variance > 65535) e.variance = 65535;
    v = (e.variance == 0) ? 1 : e.variance;
    k = 0;
    while ((v >> (k + 1)) != 0) k++;
    f = ((v << 15) >> k) & 32'h7FFF;
    y = 32768 - ((f * 9598) >> 15);
    if (k % 2 == 1) y = (y * 23170) >> 15;
    e.inv  = y >> (k / 2);
    e.bank = b;
    e.due  = due;
    return e;
  endfunction

  function automatic logic [1023:0] junk();
    logic [1023:0] d;
    for (int i = 0; i < 32; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  // One clock of stimulus; en_count numbers the enabled edges.
  task automatic cycle(logic e, logic v, logic [1023:0] d, logic r);
    @(negedge clk);
    rst = r; en = e; valid = v; data = d;
    if (e && !r) en_count++;
  endtask

  task automatic fill_alt(int even_v, int odd_v);
    for (int i = 0; i < 768; i++) row[i] = (i % 2 == 0) ? even_v : odd_v;
  endtask

  task automatic fill_random();
    int r;
    case ($urandom_range(0, 3))
      0: r = 3;
      1: r = 60;
      2: r = 300;
      default: r = 32767;
    endcase
    for (int i = 0; i < 768; i++) row[i] = int'($urandom_range(0, 2 * r)) - r;
  endtask

  // mode 0: dense, 1: random gaps/stalls, 2: 5-cycle stall at beat 5 plus 3 gaps.
  task automatic send_beats(int nbeats, int mode);
    logic [1023:0] d;
    for (int b = 0; b < nbeats; b++) begin
      if (mode == 1) begin
        repeat ($urandom_range(0, 1)) cycle(1'b1, 1'b0, junk(), 1'b0);
        repeat ($urandom_range(0, 2)) cycle(1'b0, 1'($urandom_range(0, 1)), junk(), 1'b0);
      end else if (mode == 2) begin
        if (b == 5) repeat (5) cycle(1'b0, 1'b1, junk(), 1'b0);
        if (b == 2 || b == 7 || b == 9) cycle(1'b1, 1'b0, junk(), 1'b0);
      end
      for (int i = 0; i < 64; i++) d[16*i +: 16] = 16'(row[b*64 + i]);
      cycle(1'b1, 1'b1, d, 1'b0);
    end
    if (nbeats == 12) begin
      sb_q.push_back(model(row_count % 4, en_count + 8));
      row_count++;
    end
  endtask

  task automatic idle(int n);
    repeat (n) cycle(1'b1, 1'b0, junk(), 1'b0);
  endtask

  // Monitor: one pop per o_valid seen after an enabled edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (en && !rst && out_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got o_valid=1 bank=%0d expected no result", bank);
        end else begin
          e = sb_q.pop_front();
          check("mean", longint'(mean), e.mean);
          check("variance", longint'(variance), e.variance);
          check("inv_sqrt", longint'(inv_sqrt), e.inv);
          check("bank_id", longint'(bank), e.bank);
          check("latency_edge", en_count, e.due);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; valid = 1'b0; data = '0;
    cycle(1'b0, 1'b0, junk(), 1'b1);
    cycle(1'b1, 1'b1, junk(), 1'b1);
    @(posedge clk); #1;
    check("rst_valid", longint'(out_valid), 0);
    check("rst_mean", longint'(mean), 0);
    check("rst_var", longint'(variance), 0);
    check("rst_inv", longint'(inv_sqrt), 0);
    check("rst_bank", longint'(bank), 0);

    // Directed rows back to back.
    for (int i = 0; i < 768; i++) row[i] = 100;
    send_beats(12, 0);
    fill_alt(2, -2);   send_beats(12, 0);
    fill_alt(3, 1);    send_beats(12, 0);
    fill_alt(-3, -1);  send_beats(12, 0);
    fill_alt(300, -300); send_beats(12, 0);
    idle(15);

    // Five random rows back to back.
    repeat (5) begin fill_random(); send_beats(12, 0); end
    idle(15);

    // Directed stall/gap row, then random stalls.
    for (int i = 0; i < 768; i++) row[i] = 100;
    send_beats(12, 2);
    repeat (6) begin fill_random(); send_beats(12, 1); end
    idle(20);

    // Reset after beat 6 discards the partial row.
    fill_random();
    send_beats(7, 0);
    cycle(1'b1, 1'b1, junk(), 1'b1);
    row_count = 0;
    @(posedge clk); #1;
    check("midrst_valid", longint'(out_valid), 0);
    check("midrst_mean", longint'(mean), 0);
    fill_random(); send_beats(12, 0);
    fill_alt(3, 1); send_beats(12, 1);

    for (int t = 0; t < 200 && sb_q.size() != 0; t++) idle(1);
    idle(12);
    check("queue_drained", longint'(sb_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
